// File: rtl/decode_ctrl_pkg.sv
// Shared constants and types for the decode stage: instruction types, opcodes,
// the buffered entry layout and the opcode classifier.
package decode_ctrl_pkg;

  localparam logic [4:0] INST_NONE = 5'd0;
  localparam logic [4:0] INST_R    = 5'd1;
  localparam logic [4:0] INST_I    = 5'd2;
  localparam logic [4:0] INST_S    = 5'd3;
  localparam logic [4:0] INST_B    = 5'd4;
  localparam logic [4:0] INST_U    = 5'd5;
  localparam logic [4:0] INST_J    = 5'd6;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  inst_type;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
  } entry_t;

  function automatic logic [4:0] classify(input logic [6:0] opcode);
    logic [4:0] t;
    case (opcode)
      OP_REG:                                          t = INST_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM:   t = INST_I;
      OP_STORE:                                        t = INST_S;
      OP_BRANCH:                                       t = INST_B;
      OP_LUI, OP_AUIPC:                                t = INST_U;
      OP_JAL:                                          t = INST_J;
      default:                                         t = INST_NONE;
    endcase
    return t;
  endfunction

  // funct3 001 (SLLI) and 101 (SRLI/SRAI) share funct3[1:0] == 01
  function automatic logic is_shift_imm(input logic [6:0] opcode,
                                        input logic [1:0] funct3_lo);
    return (opcode == OP_IMM) && (funct3_lo == 2'b01);
  endfunction

endpackage

// File: rtl/decode_ctrl_sext.sv
// Immediate generator: imm_in is inst[31:7]. U returns the raw 20-bit field
// sign-extended (no <<12); B/J return byte offsets with the implicit zero LSB.
module sext
  import decode_ctrl_pkg::*;
(
  input  logic [24:0] imm_in,
  input  logic [4:0]  inst_type,
  input  logic        shift_imm,
  output logic [31:0] imm_out
);

  // Bit k of the instruction lives at imm_in[k-7].
  always_comb begin
    imm_out = '0;
    case (inst_type)
      INST_I: begin
        if (shift_imm) begin
          imm_out = {27'd0, imm_in[17:13]};
        end else begin
          imm_out = {{20{imm_in[24]}}, imm_in[24:13]};
        end
      end
      INST_S: imm_out = {{20{imm_in[24]}}, imm_in[24:18], imm_in[4:0]};
      INST_B: imm_out = {{19{imm_in[24]}}, imm_in[24], imm_in[0],
                         imm_in[23:18], imm_in[4:1], 1'b0};
      INST_U: imm_out = {{12{imm_in[24]}}, imm_in[24:5]};
      INST_J: imm_out = {{11{imm_in[24]}}, imm_in[24], imm_in[12:5],
                         imm_in[13], imm_in[23:14], 1'b0};
      default: imm_out = '0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: classifies fetched instructions, generates the
// immediate and presents decoded entries from a 2-entry skid buffer.
module decode_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [4:0]      out_inst_type,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_illegal
);

  logic [1:0]  count_q, count_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  entry_t      new_entry;
  logic [4:0]  dec_type;
  logic        dec_shift;
  logic [31:0] dec_imm;
  logic        push;
  logic        pop;

  assign dec_type  = classify(in_inst[6:0]);
  assign dec_shift = is_shift_imm(in_inst[6:0], in_inst[13:12]);

  sext u_sext (
    .imm_in    (in_inst[31:7]),
    .inst_type (dec_type),
    .shift_imm (dec_shift),
    .imm_out   (dec_imm)
  );

  always_comb begin
    new_entry           = '0;
    new_entry.pc        = in_pc;
    new_entry.inst      = in_inst;
    new_entry.inst_type = dec_type;
    new_entry.imm       = dec_imm;
    new_entry.rd        = in_inst[11:7];
    new_entry.rs1       = in_inst[19:15];
    new_entry.rs2       = in_inst[24:20];
    new_entry.illegal   = (dec_type == INST_NONE);
  end

  // Ready comes only from the registered count so fetch never sees a path from out_ready.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = new_entry;
          end else begin
            tail_d = new_entry;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = new_entry;
          end else begin
            head_d = tail_q;
            tail_d = new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_pc        = head_q.pc;
  assign out_inst      = head_q.inst;
  assign out_inst_type = head_q.inst_type;
  assign out_imm       = head_q.imm;
  assign out_rd        = head_q.rd;
  assign out_rs1       = head_q.rs1;
  assign out_rs2       = head_q.rs2;
  assign out_illegal   = head_q.illegal;

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: accepted instructions are modelled and queued,
// a monitor compares the presented head entry and pops on each output handshake.
module tb_decode_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [4:0]  out_inst_type;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic        out_illegal;

  decode_ctrl #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_inst       (in_inst),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_inst_type (out_inst_type),
    .out_imm       (out_imm),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_illegal   (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  typ;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction-set rules using signed integer arithmetic.
  function automatic exp_t ref_model(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    int   s;
    int   imm;
    s = $signed(inst);
    imm = 0;
    e.pc = pc; e.inst = inst; e.ill = 1'b0;
    e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
    case (inst[6:0])
      7'h33: e.typ = 5'd1;
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
        e.typ = 5'd2;
        if (inst[6:0] == 7'h13 && (inst[14:12] == 3'd1 || inst[14:12] == 3'd5))
          imm = int'(inst[24:20]);
        else
          imm = s >>> 20;
      end
      7'h23: begin
        e.typ = 5'd3;
        imm = ((s >>> 25) <<< 5) | int'(inst[11:7]);
      end
      7'h63: begin
        e.typ = 5'd4;
        imm = ((s >>> 31) <<< 12) | (int'(inst[7]) <<< 11)
            | (int'(inst[30:25]) <<< 5) | (int'(inst[11:8]) <<< 1);
      end
      7'h37, 7'h17: begin
        e.typ = 5'd5;
        imm = s >>> 12;
      end
      7'h6F: begin
        e.typ = 5'd6;
        imm = ((s >>> 31) <<< 20) | (int'(inst[19:12]) <<< 12)
            | (int'(inst[20]) <<< 11) | (int'(inst[30:21]) <<< 1);
      end
      default: begin
        e.typ = 5'd0;
        e.ill = 1'b1;
      end
    endcase
    e.imm = imm;
    return e;
  endfunction

  // Stimulus side: record every accepted instruction (or a flush) once inputs are settled.
  always @(negedge rst_n) sb_q.delete();

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(ref_model(in_pc, in_inst));
    end
  end

  // Monitor: head entry must match the oldest expected entry and stay put until popped.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 128'(in_ready), 128'(sb_q.size() < 2));
      check("out_valid", 128'(out_valid), 128'(sb_q.size() != 0));
      if (out_valid && sb_q.size() > 0) begin
        mon_e = sb_q[0];
        check("head", {11'd0, out_pc, out_inst, out_inst_type, out_imm, out_rd, out_rs1, out_rs2, out_illegal},
              {11'd0, mon_e.pc, mon_e.inst, mon_e.typ, mon_e.imm, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.ill});
        if (out_ready && !flush) begin
          void'(sb_q.pop_front());
          $display("[TB] txn pc=%h inst=%h type=%0d imm=%h ill=%0d",
                   out_pc, out_inst, out_inst_type, out_imm, out_illegal);
        end
      end
    end
  end

  task automatic send_one(input logic [31:0] pc, input logic [31:0] inst);
    int n;
    in_pc = pc; in_inst = inst; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("drain_empty", 128'(sb_q.size()), 128'(0));
  endtask

  task automatic directed(input string nm, input logic [31:0] inst, input logic [4:0] typ,
                          input logic [31:0] imm, input logic ill, input logic [4:0] rd,
                          input logic [4:0] rs1);
    drain();
    out_ready = 1'b0;
    send_one(32'h0000_1000, inst);
    check({nm, "_valid"}, 128'(out_valid), 128'(1));
    check({nm, "_type"}, 128'(out_inst_type), 128'(typ));
    check({nm, "_imm"}, 128'(out_imm), 128'(imm));
    check({nm, "_illegal"}, 128'(out_illegal), 128'(ill));
    check({nm, "_rd_rs1"}, 128'({out_rd, out_rs1}), 128'({rd, rs1}));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [12];
    logic [31:0] r;
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
    r = $urandom;
    k = $urandom_range(0, 11);
    r[6:0] = (k == 11) ? 7'($urandom) : ops[k];
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_data", {out_pc, out_inst, out_imm, out_rd, out_rs1, out_rs2, out_inst_type, out_illegal},
          128'(0));
    rst_n = 1'b1;

    directed("addi", 32'hFFF0_0093, 5'd2, 32'hFFFF_FFFF, 1'b0, 5'd1, 5'd0);
    directed("slli", 32'h0050_9093, 5'd2, 32'h0000_0005, 1'b0, 5'd1, 5'd1);
    directed("srai", 32'h4030_D093, 5'd2, 32'h0000_0003, 1'b0, 5'd1, 5'd1);
    directed("lui", 32'h1234_50B7, 5'd5, 32'h0001_2345, 1'b0, 5'd1, 5'd8);
    directed("illegal", 32'h0000_0000, 5'd0, 32'h0000_0000, 1'b1, 5'd0, 5'd0);

    // Backpressure: two fill the buffer, a third waits, then release.
    drain();
    out_ready = 1'b0;
    send_one(32'h0000_2000, 32'h0010_0113);
    send_one(32'h0000_2004, 32'h0020_0193);
    in_pc = 32'h0000_2008; in_inst = 32'h0030_0213; in_valid = 1'b1;
    check("bp_in_ready_low", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    check("bp_head_held", 128'(out_pc), 128'(32'h0000_2000));
    out_ready = 1'b1;
    send_one(32'h0000_2008, 32'h0030_0213);
    send_one(32'h0000_200C, 32'h0040_0293);
    drain();

    // Flush with a full buffer and a same-cycle input.
    out_ready = 1'b0;
    send_one(32'h0000_3000, rand_inst());
    send_one(32'h0000_3004, rand_inst());
    in_pc = 32'h0000_DEAD; in_inst = 32'h0050_0313; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_in_ready", 128'(in_ready), 128'(1));

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_pc     = $urandom;
      in_inst   = rand_inst();
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    drain();

    // Asynchronous reset with a full buffer.
    out_ready = 1'b0;
    send_one(32'h0000_4000, rand_inst());
    send_one(32'h0000_4004, rand_inst());
    check("pre_rst_full", 128'(in_ready), 128'(0));
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 128'(out_valid), 128'(0));
    check("async_rst_in_ready", 128'(in_ready), 128'(1));
    check("async_rst_pc", 128'(out_pc), 128'(0));
    #1 rst_n = 1'b1;
    directed("post_rst_addi", 32'hFFF0_0093, 5'd2, 32'hFFFF_FFFF, 1'b0, 5'd1, 5'd0);

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
